// File: rtl/cpu_bus_sequencer.sv
// cpu_bus_sequencer: splits a 1/2/4-byte CPU access into little-endian bus beats with ready handshake and wait-state timeout
module cpu_bus_sequencer #(
    parameter int ADDR_W  = 32,
    parameter int BUS_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              i_cpu_clk,
    input  logic              i_rst,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [1:0]        i_size,
    input  logic [31:0]       i_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [31:0]       o_rdata,
    output logic              o_bus_clk,
    output logic              o_bus_we,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [BUS_W-1:0]  o_bus_data,
    input  logic [BUS_W-1:0]  i_bus_data,
    input  logic              i_bus_data_ready
);
    localparam int BB = BUS_W / 8;
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;
    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [2:0]        n_q;
    logic [1:0]        k;
    logic [1:0]        last_k;
    logic [15:0]       wcnt;
    logic [2:0]        req_n;
    logic [1:0]        req_last;
    logic [1:0]        kn;
    logic [1:0]        bi;
    logic [2:0]        src_n;
    logic [31:0]       src_wdata;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] beat_addr;
    logic [BUS_W-1:0]  lane_data;
    logic              finish;
    // Next beat's address and write lanes: from the raw request when idle, else from the latched one
    always_comb begin
        req_n     = (i_size == 2'd0) ? 3'd1 : (i_size == 2'd1) ? 3'd2 : 3'd4;
        req_last  = (int'(req_n) <= BB) ? 2'd0 : 2'(int'(req_n) / BB - 1);
        kn        = (state == IDLE) ? 2'd0 : k + 2'd1;
        src_n     = (state == IDLE) ? req_n : n_q;
        src_wdata = (state == IDLE) ? i_wdata : wdata_q;
        src_addr  = (state == IDLE) ? i_addr : addr_q;
        beat_addr = src_addr + ADDR_W'(kn) * ADDR_W'(BB);
        bi        = '0;
        lane_data = '0;
        for (int j = 0; j < BB; j++) begin
            bi = 2'(int'(kn) * BB + j);
            if (int'(kn) * BB + j < int'(src_n)) lane_data[j*8 +: 8] = src_wdata[8*bi +: 8];
        end
        finish = i_bus_data_ready ? (k == last_k) : (TIMEOUT != 0 && wcnt == 16'(TIMEOUT - 1));
    end
    always_ff @(posedge i_cpu_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            n_q        <= '0;
            k          <= '0;
            last_k     <= '0;
            wcnt       <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
            o_rdata    <= '0;
            o_bus_clk  <= 1'b0;
            o_bus_we   <= 1'b0;
            o_bus_addr <= '0;
            o_bus_data <= '0;
        end else begin
            case (state)
                IDLE: if (i_req) begin
                    addr_q     <= i_addr;
                    wdata_q    <= i_wdata;
                    n_q        <= req_n;
                    last_k     <= req_last;
                    k          <= '0;
                    o_rdata    <= '0;
                    o_err      <= 1'b0;
                    o_busy     <= 1'b1;
                    o_bus_we   <= i_we;
                    o_bus_addr <= beat_addr;
                    o_bus_data <= lane_data;
                    state      <= SETUP;
                end
                SETUP: begin
                    wcnt      <= '0;
                    o_bus_clk <= 1'b1;
                    state     <= STROBE;
                end
                STROBE: begin
                    if (i_bus_data_ready)
                        for (int j = 0; j < BB; j++)
                            if (int'(k) * BB + j < int'(n_q)) o_rdata[8*(int'(k) * BB + j) +: 8] <= i_bus_data[j*8 +: 8];
                    if (finish) begin
                        o_bus_clk <= 1'b0;
                        o_bus_we  <= 1'b0;
                        o_done    <= 1'b1;
                        o_err     <= !i_bus_data_ready;
                        state     <= DONE;
                    end else if (i_bus_data_ready) begin
                        o_bus_clk  <= 1'b0;
                        k          <= kn;
                        o_bus_addr <= beat_addr;
                        o_bus_data <= lane_data;
                        state      <= SETUP;
                    end else begin
                        wcnt <= wcnt + 16'd1;
                    end
                end
                DONE: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_bus_sequencer.sv
// tb_cpu_bus_sequencer: directed tests on an 8-bit bus instance (TIMEOUT=4) and a 16-bit bus instance
module tb_cpu_bus_sequencer;
    logic        clk, rst;
    logic        req8, we8, busy8, done8, err8, bclk8, bwe8, rdy8;
    logic [1:0]  size8;
    logic [31:0] addr8, wdata8, rdata8, baddr8, hang_a8;
    logic [7:0]  bdata8, brd8;
    logic [7:0]  mem8 [4];
    int          scnt8, wait8;
    logic        hang8;
    logic        req16, we16, busy16, done16, err16, bclk16, bwe16, rdy16;
    logic [1:0]  size16;
    logic [31:0] addr16, wdata16, rdata16, baddr16;
    logic [15:0] bdata16, brd16;
    int          checks, errors, dc, nb, we_bad;
    logic [31:0] la [8];
    logic [15:0] ld [8];

    cpu_bus_sequencer #(.ADDR_W(32), .BUS_W(8), .TIMEOUT(4)) u8 (
        .i_cpu_clk(clk), .i_rst(rst), .i_req(req8), .i_we(we8), .i_addr(addr8), .i_size(size8),
        .i_wdata(wdata8), .o_busy(busy8), .o_done(done8), .o_err(err8), .o_rdata(rdata8),
        .o_bus_clk(bclk8), .o_bus_we(bwe8), .o_bus_addr(baddr8), .o_bus_data(bdata8),
        .i_bus_data(brd8), .i_bus_data_ready(rdy8));

    cpu_bus_sequencer #(.ADDR_W(32), .BUS_W(16), .TIMEOUT(255)) u16 (
        .i_cpu_clk(clk), .i_rst(rst), .i_req(req16), .i_we(we16), .i_addr(addr16), .i_size(size16),
        .i_wdata(wdata16), .o_busy(busy16), .o_done(done16), .o_err(err16), .o_rdata(rdata16),
        .o_bus_clk(bclk16), .o_bus_we(bwe16), .o_bus_addr(baddr16), .o_bus_data(bdata16),
        .i_bus_data(brd16), .i_bus_data_ready(rdy16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus targets: 8-bit target answers after wait8 strobe cycles, never for hang_a8 when hang8 is set
    assign rdy8  = bclk8 && (scnt8 >= wait8) && !(hang8 && baddr8 == hang_a8);
    assign brd8  = mem8[baddr8[1:0]];
    assign rdy16 = bclk16;
    assign brd16 = 16'hA5C3;
    always @(posedge clk) scnt8 <= (bclk8 && !rdy8) ? scnt8 + 1 : 0;

    task automatic run8(input logic we, input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd, input bit pulse);
        nb = 0; dc = 0; we_bad = 0;
        req8 = 1'b1; we8 = we; addr8 = a; size8 = sz; wdata8 = wd;
        @(posedge clk); #1 req8 = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            req8 = pulse && c == 2;
            if (pulse && c == 2) addr8 = 32'hDEAD0000;
            if (bclk8 && rdy8 && nb < 8) begin la[nb] = baddr8; ld[nb] = 16'(bdata8); nb++; end
            if (bwe8 !== (we & busy8 & ~done8)) we_bad++;
            if (done8) begin dc = c; break; end
        end
        @(negedge clk);
        req8 = 1'b0;
    endtask

    task automatic run16(input logic we, input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        nb = 0; dc = 0; we_bad = 0;
        req16 = 1'b1; we16 = we; addr16 = a; size16 = sz; wdata16 = wd;
        @(posedge clk); #1 req16 = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (bclk16 && rdy16 && nb < 8) begin la[nb] = baddr16; ld[nb] = bdata16; nb++; end
            if (bwe16 !== (we & busy16 & ~done16)) we_bad++;
            if (done16) begin dc = c; break; end
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        checks++; if ({busy8, done8, err8, rdata8, bclk8, bwe8, baddr8, bdata8} !== '0) begin errors++;
            $display("FAIL reset8: got busy=%b done=%b err=%b rdata=%h bclk=%b bwe=%b addr=%h data=%h expected all 0", busy8, done8, err8, rdata8, bclk8, bwe8, baddr8, bdata8); end
        checks++; if ({busy16, done16, err16, rdata16, bclk16, bwe16, baddr16, bdata16} !== '0) begin errors++;
            $display("FAIL reset16: got busy=%b done=%b err=%b rdata=%h bclk=%b bwe=%b addr=%h data=%h expected all 0", busy16, done16, err16, rdata16, bclk16, bwe16, baddr16, bdata16); end
    endtask

    task automatic test_read4_bus8;
        mem8[0] = 8'h11; mem8[1] = 8'h22; mem8[2] = 8'h33; mem8[3] = 8'h44; wait8 = 0; hang8 = 1'b0;
        run8(1'b0, 32'h0000_1000, 2'd2, 32'h0, 1'b0);
        checks++; if (dc !== 9) begin errors++; $display("FAIL read4_latency: got %0d expected 9", dc); end
        checks++; if (rdata8 !== 32'h44332211) begin errors++; $display("FAIL read4_rdata: got %h expected 44332211", rdata8); end
        checks++; if (err8 !== 1'b0) begin errors++; $display("FAIL read4_err: got %b expected 0", err8); end
        checks++; if (nb !== 4) begin errors++; $display("FAIL read4_beats: got %0d expected 4", nb); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (la[i] !== 32'h1000 + 32'(i)) begin errors++; $display("FAIL read4_addr%0d: got %h expected %h", i, la[i], 32'h1000 + 32'(i)); end
        end
    endtask

    task automatic test_write_wrap;
        run8(1'b1, 32'hFFFF_FFFF, 2'd1, 32'h0000_BEEF, 1'b0);
        checks++; if (nb !== 2) begin errors++; $display("FAIL wrap_beats: got %0d expected 2", nb); end
        checks++; if (la[0] !== 32'hFFFF_FFFF || la[1] !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h %h expected ffffffff 00000000", la[0], la[1]); end
        checks++; if (ld[0] !== 16'h00EF || ld[1] !== 16'h00BE) begin errors++; $display("FAIL wrap_data: got %h %h expected ef be", ld[0], ld[1]); end
        checks++; if (dc !== 5) begin errors++; $display("FAIL wrap_latency: got %0d expected 5", dc); end
        checks++; if (we_bad !== 0) begin errors++; $display("FAIL wrap_we_window: got %0d bad cycles expected 0", we_bad); end
    endtask

    task automatic test_bus16;
        run16(1'b0, 32'h20, 2'd0, 32'h0);
        checks++; if (nb !== 1 || dc !== 3) begin errors++; $display("FAIL b16_read_beats: got beats=%0d cyc=%0d expected 1 3", nb, dc); end
        checks++; if (rdata16 !== 32'h0000_00C3) begin errors++; $display("FAIL b16_read_rdata: got %h expected 000000c3", rdata16); end
        run16(1'b1, 32'h20, 2'd2, 32'h0102_0304);
        checks++; if (nb !== 2 || dc !== 5) begin errors++; $display("FAIL b16_write_beats: got beats=%0d cyc=%0d expected 2 5", nb, dc); end
        checks++; if (ld[0] !== 16'h0304 || ld[1] !== 16'h0102) begin errors++; $display("FAIL b16_write_data: got %h %h expected 0304 0102", ld[0], ld[1]); end
        checks++; if (la[0] !== 32'h20 || la[1] !== 32'h22) begin errors++; $display("FAIL b16_write_addr: got %h %h expected 20 22", la[0], la[1]); end
        run16(1'b1, 32'h40, 2'd0, 32'h1234_56AB);
        checks++; if (nb !== 1 || ld[0] !== 16'h00AB) begin errors++; $display("FAIL b16_lane_zero: got beats=%0d data=%h expected 1 00ab", nb, ld[0]); end
        checks++; if (we_bad !== 0) begin errors++; $display("FAIL b16_we_window: got %0d bad cycles expected 0", we_bad); end
    endtask

    task automatic test_wait_and_ignore;
        mem8[1] = 8'h22; wait8 = 3; hang8 = 1'b0;
        run8(1'b0, 32'h0000_1001, 2'd0, 32'h0, 1'b1);
        checks++; if (dc !== 6) begin errors++; $display("FAIL wait_latency: got %0d expected 6", dc); end
        checks++; if (err8 !== 1'b0 || rdata8 !== 32'h22) begin errors++; $display("FAIL wait_ready_wins: got err=%b rdata=%h expected 0 00000022", err8, rdata8); end
        checks++; if (nb !== 1 || la[0] !== 32'h1001) begin errors++; $display("FAIL ignore_req: got beats=%0d addr=%h expected 1 00001001", nb, la[0]); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL ignore_idle%0d: got busy=%b expected 0", i, busy8); end
            @(negedge clk);
        end
        wait8 = 0;
    endtask

    task automatic test_timeout;
        mem8[0] = 8'h7E; hang8 = 1'b1; hang_a8 = 32'h301; wait8 = 0;
        run8(1'b0, 32'h300, 2'd1, 32'h0, 1'b0);
        checks++; if (dc !== 8) begin errors++; $display("FAIL timeout_latency: got %0d expected 8", dc); end
        checks++; if (rdata8 !== 32'h0000_007E) begin errors++; $display("FAIL timeout_rdata: got %h expected 0000007e", rdata8); end
        checks++; if (err8 !== 1'b1 || busy8 !== 1'b0 || bclk8 !== 1'b0) begin errors++; $display("FAIL timeout_idle: got err=%b busy=%b bclk=%b expected 1 0 0", err8, busy8, bclk8); end
        hang8 = 1'b0;
    endtask

    task automatic test_back_to_back;
        mem8[2] = 8'h5A;
        run8(1'b0, 32'h2, 2'd0, 32'h0, 1'b0);
        checks++; if (dc !== 3 || err8 !== 1'b0 || rdata8 !== 32'h5A) begin errors++; $display("FAIL b2b_after_err: got cyc=%0d err=%b rdata=%h expected 3 0 0000005a", dc, err8, rdata8); end
        run8(1'b1, 32'h10, 2'd0, 32'h77, 1'b0);
        checks++; if (dc !== 3 || ld[0] !== 16'h0077) begin errors++; $display("FAIL b2b_second: got cyc=%0d data=%h expected 3 0077", dc, ld[0]); end
    endtask

    task automatic test_reset_mid;
        req8 = 1'b1; we8 = 1'b1; addr8 = 32'h500; size8 = 2'd2; wdata8 = 32'hAABBCCDD;
        @(posedge clk); #1 req8 = 1'b0;
        @(negedge clk); @(negedge clk);
        checks++; if (bclk8 !== 1'b1 || bwe8 !== 1'b1 || baddr8 !== 32'h500) begin errors++; $display("FAIL mid_strobe: got bclk=%b bwe=%b addr=%h expected 1 1 00000500", bclk8, bwe8, baddr8); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({busy8, done8, err8, rdata8, bclk8, bwe8, baddr8, bdata8} !== '0) begin errors++;
            $display("FAIL mid_reset: got busy=%b done=%b err=%b rdata=%h bclk=%b bwe=%b addr=%h data=%h expected all 0", busy8, done8, err8, rdata8, bclk8, bwe8, baddr8, bdata8); end
        rst = 1'b0;
        mem8[0] = 8'h11; mem8[1] = 8'h22; mem8[2] = 8'h33; mem8[3] = 8'h44;
        run8(1'b0, 32'h600, 2'd2, 32'h0, 1'b0);
        checks++; if (dc !== 9 || rdata8 !== 32'h44332211 || la[0] !== 32'h600) begin errors++; $display("FAIL mid_recover: got cyc=%0d rdata=%h addr0=%h expected 9 44332211 00000600", dc, rdata8, la[0]); end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; req8 = 1'b0; we8 = 1'b0; addr8 = '0; size8 = '0; wdata8 = '0;
        req16 = 1'b0; we16 = 1'b0; addr16 = '0; size16 = '0; wdata16 = '0;
        wait8 = 0; hang8 = 1'b0; hang_a8 = '0;
        for (int i = 0; i < 4; i++) mem8[i] = '0;
        repeat (2) @(negedge clk);
        test_reset;
        rst = 1'b0;
        @(negedge clk);
        test_read4_bus8;
        test_write_wrap;
        test_bus16;
        test_wait_and_ignore;
        test_timeout;
        test_back_to_back;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
